// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants, response record and id-width helper for adder_arbiter
package adder_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_ID_W  = 3;
  localparam int MAX_WIDTH = 64;

  // Sized for the largest supported configuration; the top slices what it needs.
  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic                 cout;
    logic [MAX_WIDTH-1:0] sum;
  } rsp_t;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_grant.sv
// rtl/adder_arbiter_rr_grant.sv - one-hot grant search starting at ptr_i; ptr_i tied to 0 gives fixed priority
module rr_grant #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           en_i,
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  int             pos;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      cand = IDW'(pos);
      if (en_i && !found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - one shared WIDTH-bit adder behind a valid/ready arbiter with a single response slot
// ADDER_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  logic               rsp_valid_q, rsp_valid_d;
  rsp_t               rsp_q, rsp_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr;
  logic               grant_en;
  logic               accept;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [WIDTH:0]     sum_w;
  logic               unused_rsp_bits;

  // Reset is folded in so no requester sees a grant while the slot is being cleared.
  assign grant_en = rst_n & (~rsp_valid_q | rsp_ready);

  rr_grant #(.N(NUM_REQ), .IDW(ID_W)) u_grant (
    .en_i  (grant_en),
    .req_i (req_valid),
    .ptr_i (ptr),
    .gnt_o (grant),
    .idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

`ifdef ADDER_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign a_sel = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign sum_w = {1'b0, a_sel} + {1'b0, b_sel};

  // Data fields only change on accept, so a drain leaves the last result visible.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.id    = MAX_ID_W'(grant_idx);
      rsp_d.cout  = sum_w[WIDTH];
      rsp_d.sum   = MAX_WIDTH'(sum_w[WIDTH-1:0]);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_q.id[ID_W-1:0];
  assign rsp_cout        = rsp_q.cout;
  assign rsp_sum         = rsp_q.sum[WIDTH-1:0];
  assign unused_rsp_bits = ^rsp_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter; follows ADDER_ARB_RR_EN when defined
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [1:0]  id;
    logic        cout;
    logic [31:0] sum;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  exp_t        sb[$];
  logic        mv      = 1'b0;
  int          mptr    = 0;
  logic [1:0]  ml_id   = '0;
  logic        ml_cout = 1'b0;
  logic [31:0] ml_sum  = '0;
  logic [N-1:0] acc_q  = '0;

  int n_vec = 0;
  int n_bad = 0;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int          w;
    logic [N-1:0] eg;
    logic [32:0] s;
    exp_t        e;
    w  = -1;
    eg = '0;
    if (rst_n && (!mv || rsp_ready)) w = arb(req_valid, mptr);
    if (w >= 0) eg[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(eg));
    check("rsp_valid", 64'(rsp_valid), 64'(mv));
    check("rsp_id",    64'(rsp_id),    64'(ml_id));
    check("rsp_sum",   64'(rsp_sum),   64'(ml_sum));
    check("rsp_cout",  64'(rsp_cout),  64'(ml_cout));
    if (rst_n && mv && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("sb_id",  64'(rsp_id),   64'(e.id));
        check("sb_sum", 64'(rsp_sum),  64'(e.sum));
        check("sb_cout",64'(rsp_cout), 64'(e.cout));
      end
    end
    acc_q = req_valid & req_ready;
    if (!rst_n) begin
      mv = 1'b0; mptr = 0; ml_id = '0; ml_sum = '0; ml_cout = 1'b0;
      sb.delete();
    end else if (w >= 0) begin
      s       = {1'b0, op_a[w]} + {1'b0, op_b[w]};
      ml_id   = 2'(w);
      ml_sum  = s[31:0];
      ml_cout = s[32];
      mv      = 1'b1;
      sb.push_back('{id: 2'(w), cout: s[32], sum: s[31:0]});
`ifdef ADDER_ARB_RR_EN
      mptr = (w + 1) % N;
`endif
    end else if (rsp_ready) begin
      mv = 1'b0;
    end
  end

  // mode 0: drop accepted requests; 1: refill every idle requester; 2: random traffic
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_q[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1))) begin
        op_a[i] = $urandom;
        op_b[i] = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_valid[i] = 1'b1;
      end
    end
    if (mode == 2) rsp_ready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && req_valid != '0; n++) step(0);
    check("idle_timeout", 64'(req_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    repeat (2) step(0);
    rst_n = 1'b1;
    step(0);

    op_a[0] = 32'h0000_0004; op_b[0] = 32'h0040_0000;
    req_valid = 4'b0001; rsp_ready = 1'b1;
    step(0); step(0);

    op_a[2] = 32'hFFFF_FFFF; op_b[2] = 32'h0000_0002;
    req_valid[2] = 1'b1;
    step(0); step(0);

    for (int i = 0; i < N; i++) begin op_a[i] = 32'h100 * i; op_b[i] = 32'h7 + i; end
    req_valid = 4'b1111;
    repeat (8) step(1);
    wait_idle();
    step(0);

    op_a[0] = 32'h1111_0000; op_b[0] = 32'h0000_2222;
    req_valid[0] = 1'b1; rsp_ready = 1'b0;
    step(0);
    op_a[1] = 32'h8000_0000; op_b[1] = 32'h8000_0001;
    req_valid[1] = 1'b1;
    repeat (3) step(0);
    rsp_ready = 1'b1;
    step(0); step(0);
    wait_idle();

    rsp_ready = 1'b0;
    op_a[3] = 32'hDEAD_0000; op_b[3] = 32'h0000_BEEF;
    req_valid[3] = 1'b1;
    step(0);
    rst_n = 1'b0;
    step(0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (6) step(1);
    wait_idle();

    repeat (300) step(2);
    rsp_ready = 1'b1;
    wait_idle();
    step(0); step(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
